// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: registers a resolved EX control-transfer decision,
// presents the redirect target to the PC mux for one accepted cycle, then holds
// the IF/ID and ID/EX flushes for FLUSH_CYCLES non-stalled cycles in total.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       decision,
  input  logic [31:0]      br_target,
  input  logic [31:0]      jalr_target,
  input  logic             stall,
  output logic [1:0]       pc_sel,
  output logic [31:0]      redirect_pc,
  output logic             redirect_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  // Remaining FLUSH-state cycles after the REDIRECT cycle, minus one.
  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 2);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic             mis_q, mis_d;
  logic [31:0]      tgt;
  logic             accept;

  // Target formation; JALR target has its LSB forced to zero.
  always_comb begin
    tgt    = (decision == 2'b10) ? {jalr_target[31:1], 1'b0} : br_target;
    accept = ex_valid && (decision == 2'b01 || decision == 2'b10) && !stall;
  end

  // Next-state logic; decisions are only looked at while idle (later ones are wrong-path).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    mis_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (tgt[1]) begin
            mis_d = 1'b1;
          end else begin
            pc_d    = tgt;
            state_d = StRedirect;
          end
        end
      end
      StRedirect: begin
        if (!stall) begin
          if (taken_q != CntMax) taken_d = taken_q + CNT_W'(1);
          if (FLUSH_CYCLES == 1) begin
            state_d = StIdle;
          end else begin
            cnt_d   = FlushLoad;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (!stall) begin
          if (cnt_q == 4'd0) state_d = StIdle;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      taken_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs decode directly from state so reset clears them immediately.
  always_comb begin
    redirect_valid = (state_q == StRedirect);
    pc_sel         = redirect_valid ? 2'b01 : 2'b00;
    flush_if_id    = (state_q != StIdle);
    flush_id_ex    = (state_q != StIdle);
    busy           = (state_q != StIdle);
    redirect_pc    = pc_q;
    misalign_err   = mis_q;
    taken_cnt      = taken_q;
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (default parameters, and
// FLUSH_CYCLES=3/CNT_W=2) driven by shared stimulus, compared each cycle
// against a flush-budget reference model.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  decision;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic        stall;

  logic [1:0]  pc_sel [2];
  logic [31:0] rpc [2];
  logic        rv [2];
  logic        fie [2];
  logic        fde [2];
  logic        mis [2];
  logic        bsy [2];
  logic [15:0] tc0;
  logic [1:0]  tc1;

  int unsigned n_chk;
  int unsigned n_pass;

  // Reference model: m_rem = flush cycles still owed, m_redir = redirect on display.
  int          fc [2]   = '{2, 3};
  int          cmax [2] = '{65535, 3};
  bit          m_redir [2];
  int          m_rem [2];
  logic [31:0] m_pc [2];
  int          m_cnt [2];
  bit          m_mis [2];

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .decision(decision),
    .br_target(br_target), .jalr_target(jalr_target), .stall(stall),
    .pc_sel(pc_sel[0]), .redirect_pc(rpc[0]), .redirect_valid(rv[0]),
    .flush_if_id(fie[0]), .flush_id_ex(fde[0]), .misalign_err(mis[0]),
    .busy(bsy[0]), .taken_cnt(tc0)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .decision(decision),
    .br_target(br_target), .jalr_target(jalr_target), .stall(stall),
    .pc_sel(pc_sel[1]), .redirect_pc(rpc[1]), .redirect_valid(rv[1]),
    .flush_if_id(fie[1]), .flush_id_ex(fde[1]), .misalign_err(mis[1]),
    .busy(bsy[1]), .taken_cnt(tc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_redir[i] = 0;
      m_rem[i]   = 0;
      m_pc[i]    = '0;
      m_cnt[i]   = 0;
      m_mis[i]   = 0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    bit          acc;
    tgt = (decision == 2'd2) ? (jalr_target & 32'hFFFF_FFFE) : br_target;
    acc = ex_valid && (decision == 2'd1 || decision == 2'd2) && !stall;
    for (int i = 0; i < 2; i++) begin
      m_mis[i] = 0;
      if (m_rem[i] == 0) begin
        if (acc && (tgt % 4 >= 2)) m_mis[i] = 1;
        else if (acc) begin
          m_redir[i] = 1;
          m_rem[i]   = fc[i];
          m_pc[i]    = tgt;
        end
      end else if (!stall) begin
        if (m_redir[i]) begin
          m_redir[i] = 0;
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
        m_rem[i]--;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] tc;
    for (int i = 0; i < 2; i++) begin
      tc = (i == 0) ? {16'd0, tc0} : {30'd0, tc1};
      check($sformatf("pc_sel%0d", i), {30'd0, pc_sel[i]}, m_redir[i] ? 32'd1 : 32'd0);
      check($sformatf("redirect_valid%0d", i), {31'd0, rv[i]}, {31'd0, m_redir[i]});
      check($sformatf("redirect_pc%0d", i), rpc[i], m_pc[i]);
      check($sformatf("flush_if_id%0d", i), {31'd0, fie[i]}, (m_rem[i] > 0) ? 32'd1 : 32'd0);
      check($sformatf("flush_id_ex%0d", i), {31'd0, fde[i]}, (m_rem[i] > 0) ? 32'd1 : 32'd0);
      check($sformatf("busy%0d", i), {31'd0, bsy[i]}, (m_rem[i] > 0) ? 32'd1 : 32'd0);
      check($sformatf("misalign_err%0d", i), {31'd0, mis[i]}, {31'd0, m_mis[i]});
      check($sformatf("taken_cnt%0d", i), tc, 32'(m_cnt[i]));
    end
  endtask

  // Inputs are driven 1 time unit after an edge; outputs sampled 1 unit after the next.
  task automatic step(input logic v, input logic [1:0] d, input logic [31:0] bt,
                      input logic [31:0] jt, input logic st);
    ex_valid    = v;
    decision    = d;
    br_target   = bt;
    jalr_target = jt;
    stall       = st;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    ex_valid = 1'b0;
    decision = 2'd0;
    br_target = '0;
    jalr_target = '0;
    stall = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with no decision.
    for (int k = 0; k < 10; k++) step(1'b1, 2'd0, 32'h0000_0100, 32'd0, 1'b0);

    // Taken branch to 0x100.
    step(1'b1, 2'd1, 32'h0000_0100, 32'd0, 1'b0);
    check("br_redirect_pc", rpc[0], 32'h0000_0100);
    check("br_pc_sel", {30'd0, pc_sel[0]}, 32'd1);
    idle(4);
    check("br_taken_cnt", {16'd0, tc0}, 32'd1);

    // Misaligned JALR target, then aligned one after LSB clear.
    step(1'b1, 2'd2, 32'd0, 32'h0000_2003, 1'b0);
    check("jalr_misalign", {31'd0, mis[0]}, 32'd1);
    check("jalr_mis_nobusy", {31'd0, bsy[0]}, 32'd0);
    idle(1);
    check("jalr_mis_pulse_end", {31'd0, mis[0]}, 32'd0);
    step(1'b1, 2'd2, 32'd0, 32'h0000_2001, 1'b0);
    check("jalr_redirect_pc", rpc[0], 32'h0000_2000);
    idle(4);

    // Reserved decision never accepted.
    step(1'b1, 2'd3, 32'h0000_0500, 32'h0000_0600, 1'b0);
    idle(1);

    // Stall while idle, then stall while in REDIRECT.
    step(1'b1, 2'd1, 32'h0000_0200, 32'd0, 1'b1);
    step(1'b1, 2'd1, 32'h0000_0200, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("stall_hold_rv", {31'd0, rv[0]}, 32'd1);
    idle(4);

    // Wrong-path decision during FLUSH is ignored; accepted in following IDLE.
    step(1'b1, 2'd1, 32'h0000_0300, 32'd0, 1'b0);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 2'd1, 32'h0000_0400, 32'd0, 1'b0);
    check("wrongpath_pc", rpc[0], 32'h0000_0300);
    step(1'b1, 2'd1, 32'h0000_0400, 32'd0, 1'b0);
    check("backtoback_pc", rpc[0], 32'h0000_0400);
    idle(4);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] bt;
      bt = $urandom & 32'hFFFF_FFFE;
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), bt, $urandom,
           1'($urandom_range(0, 3) == 0));
    end
    idle(5);

    // Asynchronous reset between edges while in FLUSH.
    step(1'b1, 2'd1, 32'h0000_0700, 32'd0, 1'b0);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bsy[0]}, 32'd0);
    check("arst_flush", {31'd0, fie[0]}, 32'd0);
    check("arst_taken_cnt", {16'd0, tc0}, 32'd0);
    check("arst_redirect_pc", rpc[0], 32'd0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation of the narrow counter.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'd1, 32'h0000_1000 + 32'(k * 8), 32'd0, 1'b0);
      idle(4);
    end
    check("sat_taken_cnt_b", {30'd0, tc1}, 32'd3);
    check("taken_cnt_a", {16'd0, tc0}, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
